br_csr_axil_initiator: RTL and testbench
========================================

# br_csr_axil_initiator

Converts single-outstanding CSR requests into AXI4-Lite initiator transactions and returns the AXI response as a CSR response. It drives the AXI4-Lite bus toward a register target, or toward a `br_csr_axil_widget` whose CSR side is a requester. It is the counterpart of the AXI4-Lite-to-CSR widget and lets CSR-native masters reach AXI4-Lite register spaces. Only one transaction is in flight at any time.

## Interface
- AddrWidth, 32: address width; must be ≥1.
- DataWidth, 32: data width; must be 32 or 64.
- MaxTimeoutCycles, 1000: upper bound for `timeout_cycles`. Present only with the macro.
- StrobeWidth: localparam, DataWidth/8.
- TimerWidth: localparam, clamped_clog2(MaxTimeoutCycles+1).
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- csr_req_valid / csr_req_ready  in / out  1  CSR request handshake.
- csr_req_write  in  1  1 = write, 0 = read.
- csr_req_addr  in  AddrWidth  request address.
- csr_req_wdata  in  DataWidth  write data.
- csr_req_wstrb  in  StrobeWidth  write strobes.
- csr_req_secure, csr_req_privileged  in  1  access attributes.
- csr_resp_valid  out  1  one-cycle response pulse.
- csr_resp_rdata  out  DataWidth  read data.
- csr_resp_slverr, csr_resp_decerr  out  1  error flags; never both high.
- axil_aw*, axil_w*, axil_b*, axil_ar*, axil_r*  AXI4-Lite initiator ports:
  - valid/ready on every channel;
  - awaddr and araddr are AddrWidth;
  - awprot and arprot are 3 bits;
  - wdata is DataWidth; wstrb is StrobeWidth;
  - bresp and rresp are 2 bits.
- timeout_cycles  in  TimerWidth  response timeout; 0 disables the timeout. Present only with the macro.

## Operation
- The FSM has five states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP. DRAIN is added only with the macro.
- `csr_req_ready` is high only in IDLE.
  - A request is accepted on valid && ready.
  - The request fields are registered at acceptance.
- Accepted write: the FSM goes to WR_REQ.
  - `awvalid` and `wvalid` both assert.
  - Each deasserts independently after its own handshake.
  - When both handshakes are done, the FSM goes to WR_RESP with `bready` = 1.
- Accepted read: the FSM goes to RD_REQ with `arvalid` = 1.
  - After the AR handshake, the FSM goes to RD_RESP with `rready` = 1.
- AXI payload encoding:
  - awprot/arprot = {1'b0, !secure, privileged}.
  - awaddr/araddr, wdata and wstrb are copied from the registered request.
- Response decode applies to both B and R handshakes:
  - 00 and 01 → no error.
  - 10 → slverr.
  - 11 → decerr.
- After a B or R handshake:
  - `csr_resp_valid` pulses in the next cycle.
  - The FSM returns to IDLE in that same cycle.
- Read data: `csr_resp_rdata` = captured rdata, including on an error response. For write responses it is 0.
- All AXI valids and `csr_resp_*` are registered outputs, never combinational from inputs. The AXI valids stay stable until their handshake.
- Reset mid-operation: the FSM returns to IDLE immediately and any outstanding AXI transaction is abandoned. The system must reset the target together with this block.

## Timing
- Reset values while rst_n is low: every output is 0, including `csr_req_ready`.
- `csr_req_ready` = 1 from the first clk edge after rst_n deasserts.
- Minimum latency, with the target always ready and responding in the same cycle:
  - cycle 0: request accepted;
  - cycle 1: aw/w valid (or ar valid);
  - cycle 2: b (or r) handshake;
  - cycle 3: `csr_resp_valid`;
  - the next request can be accepted in cycle 3.
- Asymmetric write handshakes: AW and W may complete in different cycles. `bready` asserts only after both have completed. A B beat that arrives earlier is held off by `bready` = 0.
- Back-to-back throughput: one transaction per 3 cycles at best.

## Configuration
- Macro: `BR_CSR_AXIL_INITIATOR_TIMEOUT_EN`.
- Defined:
  - The timer clears on acceptance and increments each cycle outside IDLE and DRAIN.
  - When timer == timeout_cycles (nonzero) and there is no B/R handshake in that cycle:
    - `csr_resp_valid` pulses with slverr = 1 and rdata = 0;
    - the FSM goes to DRAIN.
  - DRAIN:
    - pending aw/w/ar valids stay asserted until their handshakes;
    - bready/rready go high once the address and data handshakes are done;
    - the late response is discarded without a CSR pulse;
    - the FSM then returns to IDLE.
  - A response handshake in the expiry cycle takes priority: the normal response is sent and no timeout occurs.
- Undefined: there is no timer, no DRAIN state and no `timeout_cycles` or MaxTimeoutCycles. The block waits indefinitely for a response.

## Structure
- `br_amba` package: AXI response encodings (OKAY/EXOKAY/SLVERR/DECERR constants) and the prot build/decode functions shared with the widget.
- Local: FSM state enum.
- Sub-module: `br_csr_axil_initiator_timer`, a clearable up-counter with an expiry compare. It is instantiated only under the macro.

## Test plan
- Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, secure = 1, priv = 0; target always ready, bresp = 00 → awaddr 0x10, awprot 3'b000, `csr_resp_valid` in cycle 3 with rdata 0 and no errors.
- Read addr 0x20; arready delayed 5 cycles; rdata 0x12345678, rresp = 11 → arvalid held stable 6 cycles; response has rdata 0x12345678 and decerr = 1.
- Write with wready 3 cycles after awready; bvalid presented early → bready = 0 until W completes; exactly one response.
- Reset mid-write, rst_n low in WR_REQ → all outputs 0 asynchronously; ready = 1 one cycle after release.
- Timeout (macro on): timeout_cycles = 4, read with no rvalid → slverr pulse with rdata 0; ready stays 0 until a late rvalid is accepted; no second pulse.
- Timeout race (macro on): rvalid handshake in the expiry cycle with rresp = 00 → normal response, no slverr, no DRAIN.

Source files
------------

// File: rtl/br_amba_pkg.sv
// Shared AXI4-Lite definitions: response encodings, prot helpers, width helper.
package br_amba;

    localparam int unsigned AXI_RESP_WIDTH = 2;
    localparam int unsigned AXI_PROT_WIDTH = 3;

    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

    // prot = {instruction(0), non-secure, privileged}
    function automatic logic [AXI_PROT_WIDTH-1:0] build_prot(input logic secure,
                                                            input logic privileged);
        return {1'b0, !secure, privileged};
    endfunction

    function automatic logic prot_is_secure(input logic [AXI_PROT_WIDTH-1:0] prot);
        return !prot[1];
    endfunction

    function automatic logic prot_is_privileged(input logic [AXI_PROT_WIDTH-1:0] prot);
        return prot[0];
    endfunction

    // $clog2 that never returns less than 1, so counters always have a bit.
    function automatic int unsigned clamped_clog2(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/br_csr_axil_initiator_timer.sv
// Clearable saturating up-counter with an expiry compare against a runtime limit.
// A limit of zero never expires.
module br_csr_axil_initiator_timer #(
    parameter int unsigned Width = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [Width-1:0] i_limit,
    output logic             o_expired_c
);

    logic [Width-1:0] r_count;

    // Count active cycles; clear wins over increment, saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {Width{1'b1}})) begin
            r_count <= r_count + Width'(1);
        end
    end

    assign o_expired_c = (i_limit != '0) && (r_count == i_limit);

endmodule

// File: rtl/br_csr_axil_initiator.sv
// CSR request -> AXI4-Lite initiator bridge, one transaction in flight.
// Optional response timeout with drain: define BR_CSR_AXIL_INITIATOR_TIMEOUT_EN.
module br_csr_axil_initiator
    import br_amba::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
    parameter int unsigned MaxTimeoutCycles = 1000,
    localparam int unsigned TimerWidth = clamped_clog2(MaxTimeoutCycles + 1),
`endif
    localparam int unsigned StrobeWidth = DataWidth / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // CSR request
    input  logic                   csr_req_valid,
    output logic                   csr_req_ready,
    input  logic                   csr_req_write,
    input  logic [AddrWidth-1:0]   csr_req_addr,
    input  logic [DataWidth-1:0]   csr_req_wdata,
    input  logic [StrobeWidth-1:0] csr_req_wstrb,
    input  logic                   csr_req_secure,
    input  logic                   csr_req_privileged,
    // CSR response
    output logic                   csr_resp_valid,
    output logic [DataWidth-1:0]   csr_resp_rdata,
    output logic                   csr_resp_slverr,
    output logic                   csr_resp_decerr,
    // AXI4-Lite write address
    output logic                   axil_awvalid,
    input  logic                   axil_awready,
    output logic [AddrWidth-1:0]   axil_awaddr,
    output logic [2:0]             axil_awprot,
    // AXI4-Lite write data
    output logic                   axil_wvalid,
    input  logic                   axil_wready,
    output logic [DataWidth-1:0]   axil_wdata,
    output logic [StrobeWidth-1:0] axil_wstrb,
    // AXI4-Lite write response
    input  logic                   axil_bvalid,
    output logic                   axil_bready,
    input  logic [1:0]             axil_bresp,
    // AXI4-Lite read address
    output logic                   axil_arvalid,
    input  logic                   axil_arready,
    output logic [AddrWidth-1:0]   axil_araddr,
    output logic [2:0]             axil_arprot,
    // AXI4-Lite read data
    input  logic                   axil_rvalid,
    output logic                   axil_rready,
    input  logic [DataWidth-1:0]   axil_rdata,
    input  logic [1:0]             axil_rresp
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
    ,
    input  logic [TimerWidth-1:0]  timeout_cycles
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
    localparam logic [2:0] ST_DRAIN   = 3'd5;
`endif

    logic [2:0]             r_state,      w_state_nxt;
    logic                   r_req_ready,  w_req_ready_nxt;
    logic [AddrWidth-1:0]   r_addr,       w_addr_nxt;
    logic [DataWidth-1:0]   r_wdata,      w_wdata_nxt;
    logic [StrobeWidth-1:0] r_wstrb,      w_wstrb_nxt;
    logic [2:0]             r_prot,       w_prot_nxt;
    logic                   r_awvalid,    w_awvalid_nxt;
    logic                   r_wvalid,     w_wvalid_nxt;
    logic                   r_bready,     w_bready_nxt;
    logic                   r_arvalid,    w_arvalid_nxt;
    logic                   r_rready,     w_rready_nxt;
    logic                   r_resp_valid, w_resp_valid_nxt;
    logic [DataWidth-1:0]   r_rdata,      w_rdata_nxt;
    logic                   r_slverr,     w_slverr_nxt;
    logic                   r_decerr,     w_decerr_nxt;

    logic w_accept;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;
    logic w_r_hs;

    assign w_accept  = csr_req_valid && r_req_ready;
    assign w_aw_done = !r_awvalid || axil_awready;
    assign w_w_done  = !r_wvalid || axil_wready;
    assign w_b_hs    = axil_bvalid && r_bready;
    assign w_r_hs    = axil_rvalid && r_rready;

`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
    logic r_write, w_write_nxt;
    logic w_timer_en;
    logic w_expired_c;

    assign w_timer_en = (r_state != ST_IDLE) && (r_state != ST_DRAIN);

    br_csr_axil_initiator_timer #(
        .Width(TimerWidth)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_accept),
        .i_en       (w_timer_en),
        .i_limit    (timeout_cycles),
        .o_expired_c(w_expired_c)
    );
`endif

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_prot       <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_slverr     <= 1'b0;
            r_decerr     <= 1'b0;
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
            r_write      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_prot       <= w_prot_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_rdata      <= w_rdata_nxt;
            r_slverr     <= w_slverr_nxt;
            r_decerr     <= w_decerr_nxt;
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
            r_write      <= w_write_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_wstrb_nxt      = r_wstrb;
        w_prot_nxt       = r_prot;
        w_awvalid_nxt    = r_awvalid;
        w_wvalid_nxt     = r_wvalid;
        w_bready_nxt     = r_bready;
        w_arvalid_nxt    = r_arvalid;
        w_rready_nxt     = r_rready;
        w_resp_valid_nxt = 1'b0;
        w_rdata_nxt      = '0;
        w_slverr_nxt     = 1'b0;
        w_decerr_nxt     = 1'b0;
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
        w_write_nxt      = r_write;
`endif

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_addr_nxt  = csr_req_addr;
                    w_wdata_nxt = csr_req_wdata;
                    w_wstrb_nxt = csr_req_wstrb;
                    w_prot_nxt  = build_prot(csr_req_secure, csr_req_privileged);
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
                    w_write_nxt = csr_req_write;
`endif
                    if (csr_req_write) begin
                        w_state_nxt   = ST_WR_REQ;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RD_REQ;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                if (axil_awready) w_awvalid_nxt = 1'b0;
                if (axil_wready)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt      = ST_IDLE;
                    w_bready_nxt     = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_slverr_nxt     = (axil_bresp == AXI_RESP_SLVERR);
                    w_decerr_nxt     = (axil_bresp == AXI_RESP_DECERR);
                end
            end
            ST_RD_REQ: begin
                if (axil_arready) begin
                    w_state_nxt   = ST_RD_RESP;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (w_r_hs) begin
                    w_state_nxt      = ST_IDLE;
                    w_rready_nxt     = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_rdata_nxt      = axil_rdata;
                    w_slverr_nxt     = (axil_rresp == AXI_RESP_SLVERR);
                    w_decerr_nxt     = (axil_rresp == AXI_RESP_DECERR);
                end
            end
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
            ST_DRAIN: begin
                // Finish the abandoned transaction silently.
                if (axil_awready) w_awvalid_nxt = 1'b0;
                if (axil_wready)  w_wvalid_nxt  = 1'b0;
                if (axil_arready) w_arvalid_nxt = 1'b0;
                if (r_write) begin
                    if (w_b_hs) begin
                        w_state_nxt  = ST_IDLE;
                        w_bready_nxt = 1'b0;
                    end else if (w_aw_done && w_w_done) begin
                        w_bready_nxt = 1'b1;
                    end
                end else begin
                    if (w_r_hs) begin
                        w_state_nxt  = ST_IDLE;
                        w_rready_nxt = 1'b0;
                    end else if (!r_arvalid || axil_arready) begin
                        w_rready_nxt = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
        // Expiry: report slverr now, let DRAIN absorb the late response.
        if (w_timer_en && w_expired_c && !w_b_hs && !w_r_hs) begin
            w_state_nxt      = ST_DRAIN;
            w_resp_valid_nxt = 1'b1;
            w_rdata_nxt      = '0;
            w_slverr_nxt     = 1'b1;
            w_decerr_nxt     = 1'b0;
        end
`endif

        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    assign csr_req_ready   = r_req_ready;
    assign csr_resp_valid  = r_resp_valid;
    assign csr_resp_rdata  = r_rdata;
    assign csr_resp_slverr = r_slverr;
    assign csr_resp_decerr = r_decerr;
    assign axil_awvalid    = r_awvalid;
    assign axil_awaddr     = r_addr;
    assign axil_awprot     = r_prot;
    assign axil_wvalid     = r_wvalid;
    assign axil_wdata      = r_wdata;
    assign axil_wstrb      = r_wstrb;
    assign axil_bready     = r_bready;
    assign axil_arvalid    = r_arvalid;
    assign axil_araddr     = r_addr;
    assign axil_arprot     = r_prot;
    assign axil_rready     = r_rready;

endmodule

// File: tb/tb_br_csr_axil_initiator.sv
// Directed bench for br_csr_axil_initiator; timeout cases need BR_CSR_AXIL_INITIATOR_TIMEOUT_EN.
module tb_br_csr_axil_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_req_valid, csr_req_ready, csr_req_write;
    logic [31:0] csr_req_addr, csr_req_wdata;
    logic [3:0]  csr_req_wstrb;
    logic        csr_req_secure, csr_req_privileged;
    logic        csr_resp_valid, csr_resp_slverr, csr_resp_decerr;
    logic [31:0] csr_resp_rdata;
    logic        axil_awvalid, axil_awready;
    logic [31:0] axil_awaddr;
    logic [2:0]  axil_awprot;
    logic        axil_wvalid, axil_wready;
    logic [31:0] axil_wdata;
    logic [3:0]  axil_wstrb;
    logic        axil_bvalid, axil_bready;
    logic [1:0]  axil_bresp;
    logic        axil_arvalid, axil_arready;
    logic [31:0] axil_araddr;
    logic [2:0]  axil_arprot;
    logic        axil_rvalid, axil_rready;
    logic [31:0] axil_rdata;
    logic [1:0]  axil_rresp;
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
    logic [9:0]  timeout_cycles;
`endif

    int passed = 0;
    int total  = 0;

    br_csr_axil_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_write(csr_req_write), .csr_req_addr(csr_req_addr),
        .csr_req_wdata(csr_req_wdata), .csr_req_wstrb(csr_req_wstrb),
        .csr_req_secure(csr_req_secure), .csr_req_privileged(csr_req_privileged),
        .csr_resp_valid(csr_resp_valid), .csr_resp_rdata(csr_resp_rdata),
        .csr_resp_slverr(csr_resp_slverr), .csr_resp_decerr(csr_resp_decerr),
        .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
        .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
        .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
        .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
        .axil_bvalid(axil_bvalid), .axil_bready(axil_bready), .axil_bresp(axil_bresp),
        .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
        .axil_araddr(axil_araddr), .axil_arprot(axil_arprot),
        .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
        .axil_rdata(axil_rdata), .axil_rresp(axil_rresp)
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
        , .timeout_cycles(timeout_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one cycle; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic sec, input logic priv);
        csr_req_valid      = 1'b1;
        csr_req_write      = wr;
        csr_req_addr       = addr;
        csr_req_wdata      = wdata;
        csr_req_wstrb      = wstrb;
        csr_req_secure     = sec;
        csr_req_privileged = priv;
    endtask

    initial begin
        rst_n = 1'b0;
        csr_req_valid = 0; csr_req_write = 0; csr_req_addr = 0; csr_req_wdata = 0;
        csr_req_wstrb = 0; csr_req_secure = 0; csr_req_privileged = 0;
        axil_awready = 0; axil_wready = 0; axil_bvalid = 0; axil_bresp = 0;
        axil_arready = 0; axil_rvalid = 0; axil_rdata = 0; axil_rresp = 0;
`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
        timeout_cycles = 10'd0;
`endif

        // Reset values
        step();
        chk("rst_ready", csr_req_ready, 0);
        chk("rst_awvalid", axil_awvalid, 0);
        chk("rst_resp_valid", csr_resp_valid, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", csr_req_ready, 1);

        // Write, target always ready, minimum latency
        axil_awready = 1; axil_wready = 1; axil_bvalid = 1; axil_bresp = 2'b00;
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0);
        step();                                          // cycle 1
        csr_req_valid = 0;
        chk("wr_awvalid", axil_awvalid, 1);
        chk("wr_wvalid", axil_wvalid, 1);
        chk("wr_awaddr", axil_awaddr, 32'h10);
        chk("wr_awprot", axil_awprot, 3'b000);
        chk("wr_wdata", axil_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", axil_wstrb, 4'hF);
        chk("wr_ready_busy", csr_req_ready, 0);
        chk("wr_bready_c1", axil_bready, 0);
        step();                                          // cycle 2
        chk("wr_awvalid_c2", axil_awvalid, 0);
        chk("wr_bready_c2", axil_bready, 1);
        chk("wr_resp_c2", csr_resp_valid, 0);
        step();                                          // cycle 3
        axil_bvalid = 0;
        chk("wr_resp_valid", csr_resp_valid, 1);
        chk("wr_resp_rdata", csr_resp_rdata, 0);
        chk("wr_resp_slverr", csr_resp_slverr, 0);
        chk("wr_resp_decerr", csr_resp_decerr, 0);
        chk("wr_ready_c3", csr_req_ready, 1);
        chk("wr_bready_c3", axil_bready, 0);

        // Read, arready held off 5 cycles, DECERR response
        axil_awready = 0; axil_wready = 0;
        axil_arready = 0; axil_rvalid = 1; axil_rdata = 32'h12345678; axil_rresp = 2'b11;
        issue(0, 32'h20, 32'h0, 4'h0, 0, 1);
        step();                                          // cycle 1
        csr_req_valid = 0;
        chk("rd_araddr", axil_araddr, 32'h20);
        chk("rd_arprot", axil_arprot, 3'b011);
        for (int i = 0; i < 5; i++) begin
            chk("rd_arvalid_hold", axil_arvalid, 1);
            chk("rd_rready_low", axil_rready, 0);
            step();
        end
        axil_arready = 1;                                // cycle 6
        chk("rd_arvalid_c6", axil_arvalid, 1);
        step();                                          // cycle 7
        axil_arready = 0;
        chk("rd_arvalid_drop", axil_arvalid, 0);
        chk("rd_rready", axil_rready, 1);
        chk("rd_resp_early", csr_resp_valid, 0);
        step();                                          // cycle 8
        axil_rvalid = 0;
        chk("rd_resp_valid", csr_resp_valid, 1);
        chk("rd_resp_rdata", csr_resp_rdata, 32'h12345678);
        chk("rd_resp_decerr", csr_resp_decerr, 1);
        chk("rd_resp_slverr", csr_resp_slverr, 0);

        // Read, target ready, EXOKAY counts as success
        axil_arready = 1; axil_rvalid = 1; axil_rdata = 32'hA5A50F0F; axil_rresp = 2'b01;
        issue(0, 32'h44, 32'h0, 4'h0, 1, 1);
        step();
        csr_req_valid = 0;
        chk("rd2_arprot", axil_arprot, 3'b001);
        step();
        step();
        axil_arready = 0; axil_rvalid = 0;
        chk("rd2_resp_valid", csr_resp_valid, 1);
        chk("rd2_rdata", csr_resp_rdata, 32'hA5A50F0F);
        chk("rd2_errs", {csr_resp_slverr, csr_resp_decerr}, 2'b00);

        // Write, W three cycles after AW, early B held off, SLVERR
        axil_awready = 1; axil_wready = 0; axil_bvalid = 1; axil_bresp = 2'b10;
        issue(1, 32'h30, 32'h0000CAFE, 4'h3, 0, 0);
        step();                                          // cycle 1: AW handshake
        csr_req_valid = 0;
        chk("asy_awprot", axil_awprot, 3'b010);
        chk("asy_wvalid_c1", axil_wvalid, 1);
        for (int i = 0; i < 3; i++) begin
            step();                                      // cycles 2..4
            chk("asy_awvalid_low", axil_awvalid, 0);
            chk("asy_wvalid_hold", axil_wvalid, 1);
            chk("asy_bready_low", axil_bready, 0);
            chk("asy_no_resp", csr_resp_valid, 0);
        end
        axil_wready = 1;                                 // W handshake in cycle 4
        step();                                          // cycle 5
        axil_wready = 0;
        chk("asy_wvalid_drop", axil_wvalid, 0);
        chk("asy_bready", axil_bready, 1);
        step();                                          // cycle 6
        axil_bvalid = 0;
        chk("asy_resp_valid", csr_resp_valid, 1);
        chk("asy_slverr", csr_resp_slverr, 1);
        chk("asy_decerr", csr_resp_decerr, 0);
        step();
        chk("asy_single_pulse", csr_resp_valid, 0);
        axil_awready = 0;

        // Reset in WR_REQ
        issue(1, 32'h50, 32'h1, 4'h1, 1, 0);
        step();
        csr_req_valid = 0;
        chk("mid_awvalid_pre", axil_awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_awvalid", axil_awvalid, 0);
        chk("mid_wvalid", axil_wvalid, 0);
        chk("mid_ready", csr_req_ready, 0);
        step();
        #3 rst_n = 1'b1;
        #1;
        chk("mid_ready_rel", csr_req_ready, 0);
        step();
        chk("mid_ready_after", csr_req_ready, 1);
        chk("mid_awvalid_after", axil_awvalid, 0);

`ifdef BR_CSR_AXIL_INITIATOR_TIMEOUT_EN
        // Timeout: read with no data, then late data drained silently
        timeout_cycles = 10'd4;
        axil_arready = 1; axil_rvalid = 0; axil_rdata = 32'hFFFF0000; axil_rresp = 2'b00;
        issue(0, 32'h60, 32'h0, 4'h0, 1, 0);
        step();                                          // cycle 1
        csr_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();                                      // cycles 2..5
            chk("to_no_resp", csr_resp_valid, 0);
        end
        step();                                          // cycle 6
        axil_arready = 0;
        chk("to_pulse", csr_resp_valid, 1);
        chk("to_slverr", csr_resp_slverr, 1);
        chk("to_rdata", csr_resp_rdata, 0);
        chk("to_ready", csr_req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_drain_ready", csr_req_ready, 0);
            chk("to_drain_no_resp", csr_resp_valid, 0);
            chk("to_drain_rready", axil_rready, 1);
        end
        axil_rvalid = 1;
        step();
        axil_rvalid = 0;
        chk("to_late_no_pulse", csr_resp_valid, 0);
        chk("to_ready_back", csr_req_ready, 1);

        // Timeout race: R handshake in the expiry cycle wins
        axil_arready = 1; axil_rdata = 32'h0BADF00D; axil_rresp = 2'b00;
        issue(0, 32'h64, 32'h0, 4'h0, 1, 0);
        step();                                          // cycle 1
        csr_req_valid = 0;
        for (int i = 0; i < 4; i++) step();              // cycle 5: expiry cycle
        axil_rvalid = 1;
        step();                                          // cycle 6
        axil_rvalid = 0; axil_arready = 0;
        chk("race_resp", csr_resp_valid, 1);
        chk("race_slverr", csr_resp_slverr, 0);
        chk("race_rdata", csr_resp_rdata, 32'h0BADF00D);
        chk("race_ready", csr_req_ready, 1);
        step();
        chk("race_single", csr_resp_valid, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
